sd_cmd_master_gen2: RTL and testbench

Parametrised next-generation SD command-path master. It sits between the host register file and the serial CMD-line engine. It formats a 40-bit command token and hands it to the serial engine via a req/ack handshake, then collects the short or 136-bit long response. It adds over the previous generation:
- automatic retry on CRC/index error
- R1b busy wait on DAT0
- a parametrised watchdog that can be disabled
- a command-collision error

---
 rtl/sd_cmd_master_gen2.sv | 179 +++++++++++++++++
 tb/tb_sd_cmd_master_gen2.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cmd_master_gen2.sv
// SD command-path master: formats a 40-bit command token, hands it to the serial CMD engine,
// and collects the response. Adds CRC/index retry, R1b busy wait, a watchdog and collision flagging.
module sd_cmd_master_gen2 #(
  parameter int TIMEOUT_W   = 16,
  parameter int MAX_RETRY   = 2,
  parameter int SYNC_STAGES = 2,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic                 CLK_PAD_IO,
  input  logic                 RST_PAD_I,
  input  logic                 new_cmd_i,
  input  logic [15:0]          cmd_set_i,
  input  logic [31:0]          arg_i,
  input  logic [TIMEOUT_W-1:0] timeout_i,
  input  logic                 data_read_i,
  input  logic                 data_write_i,
  input  logic                 err_int_rst_i,
  input  logic                 normal_int_rst_i,
  output logic [39:0]          cmd_o,
  output logic [15:0]          setting_o,
  output logic                 req_o,
  output logic                 ack_o,
  input  logic                 req_i,
  input  logic                 ack_i,
  input  logic [15:0]          status_i,
  input  logic [39:0]          cmd_i,
  input  logic [127:0]         resp_long_i,
  input  logic                 busy_i,
  output logic [127:0]         resp_o,
  output logic [15:0]          err_int_o,
  output logic [15:0]          normal_int_o,
  output logic [15:0]          status_o,
  output logic [RW-1:0]        retry_cnt_o,
  output logic                 go_idle_o
);
  typedef enum logic [2:0] {IDLE, SETUP, WAIT_ACK, EXECUTE, RETRY, BUSY_WAIT} state_t;
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);

  state_t state, state_n;
  logic [SYNC_STAGES-1:0][2:0] sq;
  logic req_s, ack_s, busy_s;
  logic [15:0] cset_q;
  logic [31:0] arg_q;
  logic [3:0]  stat_hi;
  logic [TIMEOUT_W-1:0] wd_q, wd_inc;
  logic wd_run, timeout, take, rec, finish, collide, crc_err, idx_err, clr_err, clr_nrm;
  logic [15:0] err_set, nrm_set;
  logic [6:0]  rsize;
  logic unused_bits;

  assign unused_bits = ^{cset_q[15:14], cset_q[5], status_i[15:7], status_i[4], cmd_i[39:38]};
  assign {busy_s, ack_s, req_s} = sq[SYNC_STAGES-1];
  assign status_o = {stat_hi, 11'b0, state != IDLE};

  always_ff @(posedge CLK_PAD_IO) begin
    if (RST_PAD_I) sq <= '0;
    else begin
      sq[0] <= {busy_i, ack_i, req_i};
      for (int k = 1; k < SYNC_STAGES; k++) sq[k] <= sq[k-1];
    end
  end

  always_ff @(posedge CLK_PAD_IO) begin
    if (RST_PAD_I) state <= IDLE;
    else           state <= state_n;
  end

  always_comb begin
    state_n = state;
    err_set = '0;
    nrm_set = '0;
    take    = 1'b0;
    rec     = 1'b0;
    finish  = 1'b0;
    crc_err = 1'b0;
    idx_err = 1'b0;
    wd_run  = (state == WAIT_ACK) || (state == EXECUTE) || (state == BUSY_WAIT);
    wd_inc  = (&wd_q) ? wd_q : wd_q + 1'b1;
    // compare the post-increment count so the limit counts cycles spent waiting
    timeout = wd_run && (|timeout_i) && (wd_inc > timeout_i);
    collide = new_cmd_i && (state != IDLE);
    if (collide) begin
      err_set[5]  = 1'b1;
      nrm_set[15] = 1'b1;
    end
    case (state)
      IDLE:     if (new_cmd_i) state_n = SETUP;
      SETUP:    state_n = WAIT_ACK;
      WAIT_ACK: if (ack_s) state_n = EXECUTE;
      EXECUTE: begin
        if (req_s && !ack_o) begin
          take = 1'b1;
          if (status_i[6]) begin
            crc_err = cset_q[3] & ~status_i[5];
            idx_err = cset_q[4] & (cmd_i[37:32] != cmd_o[37:32]);
            if ((crc_err | idx_err) && (retry_cnt_o < MAXR)) state_n = RETRY;
            else begin
              rec        = 1'b1;
              err_set[1] = crc_err;
              err_set[3] = idx_err;
              err_set[4] = (crc_err | idx_err) && (MAX_RETRY > 0);
              if (cset_q[1:0] == 2'b11 && cset_q[2] && !(crc_err | idx_err)) state_n = BUSY_WAIT;
              else finish = 1'b1;
            end
          end
        end
      end
      RETRY:     state_n = SETUP;
      BUSY_WAIT: if (!busy_s) finish = 1'b1;
      default:   state_n = IDLE;
    endcase
    if (finish) begin
      state_n     = IDLE;
      nrm_set[0]  = 1'b1;
      nrm_set[15] = |(err_int_o | err_set);
    end
    if (timeout) begin
      state_n = IDLE;
      take    = 1'b0;
      rec     = 1'b0;
      err_set = {10'b0, collide, 5'b00001};
      nrm_set = 16'h8000;
    end
  end

  always_comb begin
    case (cset_q[1:0])
      2'b00:   rsize = 7'd0;
      2'b01:   rsize = 7'd127;
      default: rsize = 7'd40;
    endcase
  end

  assign clr_err = (state == IDLE && new_cmd_i) || err_int_rst_i;
  assign clr_nrm = (state == IDLE && new_cmd_i) || normal_int_rst_i;

  always_ff @(posedge CLK_PAD_IO) begin
    if (RST_PAD_I) begin
      cset_q <= '0; arg_q <= '0; stat_hi <= '0; wd_q <= '0;
      cmd_o <= '0; setting_o <= '0; req_o <= 1'b0; ack_o <= 1'b0;
      resp_o <= '0; err_int_o <= '0; normal_int_o <= '0;
      retry_cnt_o <= '0; go_idle_o <= 1'b0;
    end else begin
      go_idle_o    <= timeout;
      err_int_o    <= (clr_err ? 16'h0 : err_int_o) | err_set;
      normal_int_o <= (clr_nrm ? 16'h0 : normal_int_o) | nrm_set;
      if (state == IDLE && new_cmd_i) begin
        cset_q      <= cmd_set_i;
        arg_q       <= arg_i;
        retry_cnt_o <= '0;
        stat_hi     <= '0;
      end
      if (state == SETUP) begin
        cmd_o     <= {2'b01, cset_q[13:8], arg_q};
        setting_o <= {1'b0, cset_q[7:6], data_read_i, data_write_i, 3'b111, cset_q[3], rsize};
        wd_q      <= '0;
        req_o     <= 1'b1;
      end else if (wd_run) wd_q <= wd_inc;
      if (state == WAIT_ACK && ack_s) req_o <= 1'b0;
      // 4-phase: ack_o drops once the engine withdraws req, whatever state we are in
      if (take) begin
        ack_o   <= 1'b1;
        stat_hi <= status_i[3:0];
      end else if (!req_s) ack_o <= 1'b0;
      if (rec) begin
        case (cset_q[1:0])
          2'b01:        resp_o <= resp_long_i;
          2'b10, 2'b11: resp_o <= {96'b0, cmd_i[31:0]};
          default:      resp_o <= resp_o;
        endcase
      end
      if (state == RETRY) retry_cnt_o <= retry_cnt_o + 1'b1;
      if (timeout) begin
        req_o <= 1'b0;
        ack_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sd_cmd_master_gen2.sv
// Bench for sd_cmd_master_gen2: serial-engine responder plus directed and randomised
// command scenarios checked against an attempt-level model of the retry/error rules.
module tb_sd_cmd_master_gen2;
  localparam int TW = 16, MR = 2, SS = 2;

  logic clk = 1'b0, rst;
  logic new_cmd_i, data_read_i, data_write_i, err_int_rst_i, normal_int_rst_i;
  logic [15:0] cmd_set_i;
  logic [31:0] arg_i;
  logic [TW-1:0] timeout_i;
  logic [39:0] cmd_o;
  logic [15:0] setting_o;
  logic req_o, ack_o, req_i, ack_i, busy_i, go_idle_o;
  logic [15:0] status_i;
  logic [39:0] cmd_i;
  logic [127:0] resp_long_i, resp_o;
  logic [15:0] err_int_o, normal_int_o, status_o;
  logic [1:0] retry_cnt_o;

  int total = 0, bad = 0;
  int eng_reqs = 0, eng_delay = 0;
  bit eng_en = 1'b0;
  logic [15:0]  q_st[$];
  logic [39:0]  q_cmd[$];
  logic [127:0] q_long[$];

  always #5 clk = ~clk;

  sd_cmd_master_gen2 #(.TIMEOUT_W(TW), .MAX_RETRY(MR), .SYNC_STAGES(SS)) dut (
    .CLK_PAD_IO(clk), .RST_PAD_I(rst), .new_cmd_i(new_cmd_i), .cmd_set_i(cmd_set_i),
    .arg_i(arg_i), .timeout_i(timeout_i), .data_read_i(data_read_i), .data_write_i(data_write_i),
    .err_int_rst_i(err_int_rst_i), .normal_int_rst_i(normal_int_rst_i),
    .cmd_o(cmd_o), .setting_o(setting_o), .req_o(req_o), .ack_o(ack_o),
    .req_i(req_i), .ack_i(ack_i), .status_i(status_i), .cmd_i(cmd_i),
    .resp_long_i(resp_long_i), .busy_i(busy_i), .resp_o(resp_o), .err_int_o(err_int_o),
    .normal_int_o(normal_int_o), .status_o(status_o), .retry_cnt_o(retry_cnt_o),
    .go_idle_o(go_idle_o));

  // serial engine responder: ack the command, then return the next queued status/response
  initial begin
    int n, d;
    ack_i = 1'b0; req_i = 1'b0; status_i = '0; cmd_i = '0; resp_long_i = '0;
    forever begin
      @(negedge clk);
      if (eng_en && req_o && !rst) begin
        eng_reqs++;
        ack_i = 1'b1;
        n = 0;
        while (req_o && n < 200) begin @(negedge clk); n++; end
        total++;
        if (req_o) begin bad++; $display("FAIL eng_req_drop: req_o=%0b want 0", req_o); end
        ack_i = 1'b0;
        d = (eng_delay != 0) ? eng_delay : int'($urandom_range(0, 3));
        repeat (d) @(negedge clk);
        status_i    = (q_st.size() > 0) ? q_st.pop_front() : 16'h0060;
        cmd_i       = (q_cmd.size() > 0) ? q_cmd.pop_front() : 40'h0;
        resp_long_i = (q_long.size() > 0) ? q_long.pop_front() : 128'h0;
        req_i = 1'b1;
        n = 0;
        while (!ack_o && n < 200) begin @(negedge clk); n++; end
        total++;
        if (!ack_o) begin bad++; $display("FAIL eng_ack_rise: ack_o=%0b want 1", ack_o); end
        req_i = 1'b0;
        n = 0;
        while (ack_o && n < 200) begin @(negedge clk); n++; end
        total++;
        if (ack_o) begin bad++; $display("FAIL eng_ack_fall: ack_o=%0b want 0", ack_o); end
      end
    end
  end

  task automatic issue();
    @(negedge clk); new_cmd_i = 1'b1;
    @(negedge clk); new_cmd_i = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (status_o[0] && n < 3000) begin @(negedge clk); n++; end
    total++;
    if (status_o[0]) begin bad++; $display("FAIL %s_done: inhibit=%0b want 0", nm, status_o[0]); end
  endtask

  task automatic push(input logic [15:0] st, input logic [5:0] ri, input logic [31:0] d);
    q_st.push_back(st);
    q_cmd.push_back({2'b00, ri, d});
    q_long.push_back({d, ~d, d ^ 32'h5A5A5A5A, 32'h0BADF00D});
  endtask

  // walks attempts the way the retry rules describe: stop at first clean one or when retries run out
  task automatic model(input logic [15:0] cs, input logic [2:0][15:0] st, input logic [2:0][5:0] ri,
                       output int natt, output logic [15:0] e_err);
    e_err = '0; natt = 0;
    for (int a = 0; a <= MR; a++) begin
      bit c, x;
      c = cs[3] && !st[a][5];
      x = cs[4] && (ri[a] != cs[13:8]);
      natt = a + 1;
      if (!(c || x)) break;
      if (a == MR) begin e_err[1] = c; e_err[3] = x; e_err[4] = (MR > 0); end
    end
  endtask

  task automatic test_reset();
    total++; if (cmd_o !== 40'h0) begin bad++; $display("FAIL rst_cmd: got %h want 0", cmd_o); end
    total++; if (setting_o !== 16'h0) begin bad++; $display("FAIL rst_setting: got %h want 0", setting_o); end
    total++; if ({req_o, ack_o, go_idle_o} !== 3'b000) begin bad++; $display("FAIL rst_hs: got %b want 000", {req_o, ack_o, go_idle_o}); end
    total++; if (resp_o !== 128'h0) begin bad++; $display("FAIL rst_resp: got %h want 0", resp_o); end
    total++; if ({err_int_o, normal_int_o, status_o} !== 48'h0) begin bad++; $display("FAIL rst_regs: got %h want 0", {err_int_o, normal_int_o, status_o}); end
    total++; if (retry_cnt_o !== 2'd0) begin bad++; $display("FAIL rst_retry: got %0d want 0", retry_cnt_o); end
  endtask

  task automatic test_short();
    cmd_set_i = 16'h1A1A; arg_i = 32'hDEADBEEF; data_read_i = 1'b1; data_write_i = 1'b0;
    push(16'h0060, 6'd26, 32'h12345678);
    issue(); wait_done("short");
    total++; if (cmd_o !== 40'h5ADEADBEEF) begin bad++; $display("FAIL short_cmd: got %h want 5adeadbeef", cmd_o); end
    total++; if (setting_o !== 16'h17A8) begin bad++; $display("FAIL short_setting: got %h want 17a8", setting_o); end
    total++; if (resp_o !== {96'h0, 32'h12345678}) begin bad++; $display("FAIL short_resp: got %h want 12345678", resp_o); end
    total++; if (normal_int_o !== 16'h0001) begin bad++; $display("FAIL short_normal: got %h want 0001", normal_int_o); end
    total++; if (err_int_o !== 16'h0) begin bad++; $display("FAIL short_err: got %h want 0", err_int_o); end
  endtask

  task automatic test_crc_retry();
    cmd_set_i = 16'h1A1A; eng_reqs = 0;
    push(16'h0040, 6'd26, 32'h1); push(16'h0040, 6'd26, 32'h2); push(16'h0060, 6'd26, 32'h3);
    issue(); wait_done("retry");
    total++; if (eng_reqs != 3) begin bad++; $display("FAIL retry_reqs: got %0d want 3", eng_reqs); end
    total++; if (retry_cnt_o !== 2'd2) begin bad++; $display("FAIL retry_cnt: got %0d want 2", retry_cnt_o); end
    total++; if (err_int_o !== 16'h0) begin bad++; $display("FAIL retry_err: got %h want 0", err_int_o); end
    total++; if (normal_int_o !== 16'h0001) begin bad++; $display("FAIL retry_normal: got %h want 0001", normal_int_o); end
    total++; if (resp_o[31:0] !== 32'h3) begin bad++; $display("FAIL retry_resp: got %h want 3", resp_o[31:0]); end
  endtask

  task automatic test_exhausted();
    eng_reqs = 0;
    repeat (3) push(16'h0040, 6'd26, 32'hABCD);
    issue(); wait_done("exh");
    total++; if (eng_reqs != 3) begin bad++; $display("FAIL exh_reqs: got %0d want 3", eng_reqs); end
    total++; if (err_int_o !== 16'h0012) begin bad++; $display("FAIL exh_err: got %h want 0012", err_int_o); end
    total++; if (normal_int_o !== 16'h8001) begin bad++; $display("FAIL exh_normal: got %h want 8001", normal_int_o); end
  endtask

  task automatic test_timeout();
    int c = 0, n = 0;
    bit seen = 1'b0;
    eng_en = 1'b0; timeout_i = 16'd20;
    issue();
    while (!req_o && n < 20) begin @(negedge clk); n++; end
    err_int_rst_i = 1'b1;
    while (!go_idle_o && c < 100) begin
      @(negedge clk); c++;
      if (go_idle_o) err_int_rst_i = 1'b0;
    end
    err_int_rst_i = 1'b0;
    total++; if (c != 21) begin bad++; $display("FAIL to_latency: got %0d want 21", c); end
    total++; if (err_int_o !== 16'h0001) begin bad++; $display("FAIL to_err_vs_clear: got %h want 0001", err_int_o); end
    total++; if (normal_int_o !== 16'h8000) begin bad++; $display("FAIL to_normal: got %h want 8000", normal_int_o); end
    @(negedge clk);
    total++; if (go_idle_o !== 1'b0) begin bad++; $display("FAIL to_pulse: got %0b want 0", go_idle_o); end
    total++; if ({status_o[0], req_o} !== 2'b00) begin bad++; $display("FAIL to_idle: got %b want 00", {status_o[0], req_o}); end
    err_int_rst_i = 1'b1; normal_int_rst_i = 1'b1;
    @(negedge clk); err_int_rst_i = 1'b0; normal_int_rst_i = 1'b0;
    total++; if ({err_int_o, normal_int_o} !== 32'h0) begin bad++; $display("FAIL int_clear: got %h want 0", {err_int_o, normal_int_o}); end
    timeout_i = 16'd0;
    issue();
    repeat (1000) begin @(negedge clk); if (go_idle_o) seen = 1'b1; end
    total++; if (seen || err_int_o[0]) begin bad++; $display("FAIL to_disabled: go_idle=%0b err=%h want none", seen, err_int_o); end
    total++; if (status_o[0] !== 1'b1) begin bad++; $display("FAIL to_hang: inhibit=%0b want 1", status_o[0]); end
    rst = 1'b1; repeat (2) @(negedge clk); rst = 1'b0; @(negedge clk);
    total++; if ({status_o, err_int_o, normal_int_o, req_o} !== 49'h0) begin bad++; $display("FAIL rst_abandon: got %h want 0", {status_o, err_int_o, normal_int_o, req_o}); end
    eng_en = 1'b1;
  endtask

  task automatic test_r1b();
    int c = 0;
    cmd_set_i = {2'b00, 6'd7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11};
    busy_i = 1'b1;
    push(16'h0060, 6'd7, 32'hB0B0CAFE);
    issue();
    repeat (50) @(negedge clk);
    total++; if ({status_o[0], normal_int_o[0]} !== 2'b10) begin bad++; $display("FAIL r1b_wait: got %b want 10", {status_o[0], normal_int_o[0]}); end
    busy_i = 1'b0;
    while (!normal_int_o[0] && c < 20) begin @(negedge clk); c++; end
    total++; if (c != SS + 1) begin bad++; $display("FAIL r1b_latency: got %0d want %0d", c, SS + 1); end
    total++; if ({err_int_o, normal_int_o} !== 32'h00000001) begin bad++; $display("FAIL r1b_regs: got %h want 00000001", {err_int_o, normal_int_o}); end
    total++; if (resp_o !== {96'h0, 32'hB0B0CAFE}) begin bad++; $display("FAIL r1b_resp: got %h want b0b0cafe", resp_o); end
  endtask

  task automatic test_collision();
    int n = 0;
    bit up = 1'b0;
    cmd_set_i = 16'h1A1A; eng_reqs = 0; eng_delay = 20;
    push(16'h0060, 6'd26, 32'h77);
    issue();
    while (!(up && !req_o) && n < 200) begin @(negedge clk); up |= req_o; n++; end
    repeat (5) @(negedge clk);
    new_cmd_i = 1'b1; @(negedge clk); new_cmd_i = 1'b0;
    wait_done("coll");
    eng_delay = 0;
    total++; if (err_int_o !== 16'h0020) begin bad++; $display("FAIL coll_err: got %h want 0020", err_int_o); end
    total++; if (normal_int_o !== 16'h8001) begin bad++; $display("FAIL coll_normal: got %h want 8001", normal_int_o); end
    total++; if (eng_reqs != 1) begin bad++; $display("FAIL coll_ignored: reqs=%0d want 1", eng_reqs); end
  endtask

  task automatic test_random();
    logic [127:0] e_resp;
    e_resp = resp_o;
    timeout_i = 16'd1000;
    for (int it = 0; it < 25; it++) begin
      logic [5:0] idx; logic [1:0] typ, ws; logic ie, ce, be;
      logic [15:0] cs, e_err, e_nrm; logic [31:0] arg;
      logic [2:0][15:0] st; logic [2:0][5:0] ri; logic [2:0][31:0] dd;
      int natt; logic [31:0] r;
      idx = 6'($urandom); typ = 2'($urandom); ws = 2'($urandom);
      ie = 1'($urandom); ce = 1'($urandom); be = (typ == 2'b11) ? 1'b0 : 1'($urandom);
      cs = {2'b00, idx, ws, 1'b0, ie, ce, be, typ}; arg = $urandom;
      for (int a = 0; a <= MR; a++) begin
        r = $urandom;
        st[a] = {r[15:7], 1'b1, ($urandom_range(0, 3) != 0), r[4:0]};
        ri[a] = ($urandom_range(0, 3) != 0) ? idx : 6'($urandom);
        dd[a] = $urandom;
      end
      model(cs, st, ri, natt, e_err);
      e_nrm = 16'h0001 | ((e_err != 0) ? 16'h8000 : 16'h0);
      for (int a = 0; a < natt; a++) push(st[a], ri[a], dd[a]);
      if (typ == 2'b01) e_resp = {dd[natt-1], ~dd[natt-1], dd[natt-1] ^ 32'h5A5A5A5A, 32'h0BADF00D};
      else if (typ != 2'b00) e_resp = {96'h0, dd[natt-1]};
      cmd_set_i = cs; arg_i = arg; data_read_i = 1'($urandom); data_write_i = 1'($urandom);
      eng_reqs = 0;
      issue(); wait_done("rnd");
      total++;
      if (err_int_o !== e_err || normal_int_o !== e_nrm || retry_cnt_o !== 2'(natt - 1) || eng_reqs != natt) begin
        bad++;
        $display("FAIL rnd_ctl[%0d]: err=%h nrm=%h rty=%0d reqs=%0d want %h %h %0d %0d", it, err_int_o,
                 normal_int_o, retry_cnt_o, eng_reqs, e_err, e_nrm, natt - 1, natt);
      end
      total++;
      if (resp_o !== e_resp) begin bad++; $display("FAIL rnd_resp[%0d]: got %h want %h", it, resp_o, e_resp); end
      total++;
      if (cmd_o !== {2'b01, idx, arg} ||
          setting_o !== {1'b0, ws, data_read_i, data_write_i, 3'b111, ce,
                         (typ == 2'b00) ? 7'd0 : (typ == 2'b01) ? 7'd127 : 7'd40} ||
          status_o !== {st[natt-1][3:0], 12'h0}) begin
        bad++;
        $display("FAIL rnd_fmt[%0d]: cmd=%h set=%h stat=%h", it, cmd_o, setting_o, status_o);
      end
      repeat (4) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; new_cmd_i = 1'b0; cmd_set_i = '0; arg_i = '0; timeout_i = '0;
    data_read_i = 1'b0; data_write_i = 1'b0; err_int_rst_i = 1'b0; normal_int_rst_i = 1'b0;
    busy_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    eng_en = 1'b1;
    test_short();     repeat (8) @(negedge clk);
    test_crc_retry(); repeat (8) @(negedge clk);
    test_exhausted(); repeat (8) @(negedge clk);
    test_timeout();   repeat (8) @(negedge clk);
    test_r1b();       repeat (8) @(negedge clk);
    test_collision(); repeat (8) @(negedge clk);
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
